// File: rtl/ain_cond_pkg.sv
// Shared definitions for the ain_conditioner input stage: default sizing,
// per-bit debounce state encoding and the counter-width helper.
package ain_cond_pkg;

  localparam int AIN_WIDTH           = 2;
  localparam int AIN_SYNC_STAGES     = 2;
  localparam int AIN_DEBOUNCE_CYCLES = 4;

  // Per-bit debounce state: IDLE means the synchronised bit agrees with ain.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CHECK = 1'b1
  } deb_state_t;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/ain_conditioner_bit_debounce.sv
// One input bit: a synchroniser chain followed by an IDLE/CHECK debounce
// FSM. A new level is accepted only after it has been seen on
// DEBOUNCE_CYCLES consecutive synchronised samples.
module bit_debounce
  import ain_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = AIN_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = AIN_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic value,
  output logic update,
  output logic in_check
);

  localparam int            CW   = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  deb_state_t             state;
  logic [CW-1:0]          cnt;

  assign s        = sync[SYNC_STAGES-1];
  assign in_check = (state == ST_CHECK);

  // Synchroniser chain; the raw input enters at bit 0.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour and the chain really shifts.
  always_ff @(posedge clock) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], raw};
  end

  // Debounce FSM: count consecutive mismatches, accept on the last one.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      value  <= 1'b0;
      update <= 1'b0;
    end else begin
      update <= 1'b0;
      if (state == ST_IDLE) begin
        cnt <= '0;
        if (s != value) begin
          if (DEBOUNCE_CYCLES == 1) begin
            value  <= s;
            update <= 1'b1;
          end else begin
            state <= ST_CHECK;
            cnt   <= CW'(1);
          end
        end
      end else begin
        if (s == value) begin
          // Bounced back before being accepted: drop the partial count.
          state <= ST_IDLE;
          cnt   <= '0;
        end else if (cnt == LAST) begin
          value  <= s;
          update <= 1'b1;
          cnt    <= '0;
          state  <= ST_IDLE;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ain_conditioner.sv
// Input conditioner feeding the Moore detector's ain: per-bit synchronise
// and debounce, plus a one-cycle change strobe and a busy flag.
// Optional macro AIN_EVENT_COUNT_EN adds an 8-bit wrapping count of
// ain_changed pulses on port event_count.
module ain_conditioner
  import ain_cond_pkg::*;
#(
  parameter int WIDTH           = AIN_WIDTH,
  parameter int SYNC_STAGES     = AIN_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = AIN_DEBOUNCE_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] ain,
  output logic             ain_changed,
  output logic             busy
`ifdef AIN_EVENT_COUNT_EN
  ,
  output logic [7:0]       event_count
`endif
);

  logic [WIDTH-1:0] update_vec;
  logic [WIDTH-1:0] check_vec;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    bit_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clock   (clock),
      .reset   (reset),
      .raw     (raw_in[i]),
      .value   (ain[i]),
      .update  (update_vec[i]),
      .in_check(check_vec[i])
    );
  end

  // Per-bit flags are already registered, so the ORs keep both outputs
  // aligned with the cycle in which ain and the bit states change.
  assign ain_changed = |update_vec;
  assign busy        = |check_vec;

`ifdef AIN_EVENT_COUNT_EN
  // Count accepted changes; wraps naturally from 255 to 0.
  always_ff @(posedge clock) begin
    if (reset)            event_count <= '0;
    else if (ain_changed) event_count <= event_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_ain_conditioner.sv
// Self-checking bench for ain_conditioner: directed scenarios with
// hand-derived expectations, then randomised stimulus compared every cycle
// against a sliding-window model of the debounce rule.
module tb_ain_conditioner;

  localparam int W    = 2;
  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic         clock;
  logic         reset;
  logic [W-1:0] raw_in;
  logic [W-1:0] ain;
  logic         ain_changed;
  logic         busy;
`ifdef AIN_EVENT_COUNT_EN
  logic [7:0]   event_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ain_conditioner #(
    .WIDTH          (W),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .raw_in     (raw_in),
    .ain        (ain),
    .ain_changed(ain_changed),
    .busy       (busy)
`ifdef AIN_EVENT_COUNT_EN
    ,
    .event_count(event_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // s seen at an edge is the raw value sampled SYNC edges earlier (0 right
  // after reset). A bit accepts a new level when the last DEB samples of s,
  // including the current one, all differ from ain. It is busy while the
  // current run of mismatching samples is between 1 and DEB-1 long.
  logic [W-1:0] raw_hist[$];
  logic [W-1:0] s_hist[$];
  logic [W-1:0] m_ain     = '0;
  logic         m_changed = 1'b0;
  logic         m_busy    = 1'b0;
  logic [7:0]   m_evt     = '0;
  bit           model_valid = 1'b0;

  always @(posedge clock) begin
    logic [W-1:0] s_now;
    if (reset) begin
      raw_hist.delete();
      s_hist.delete();
      m_ain       = '0;
      m_changed   = 1'b0;
      m_busy      = 1'b0;
      m_evt       = '0;
      model_valid = 1'b1;
    end else begin
      s_now = (raw_hist.size() >= SYNC) ? raw_hist[raw_hist.size() - SYNC] : '0;
      raw_hist.push_back(raw_in);
      s_hist.push_back(s_now);
      m_changed = 1'b0;
      m_busy    = 1'b0;
      for (int i = 0; i < W; i++) begin
        int run;
        bit all_diff;
        if (s_hist.size() >= DEB) begin
          all_diff = 1'b1;
          for (int k = 0; k < DEB; k++)
            if (s_hist[s_hist.size() - 1 - k][i] == m_ain[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_ain[i]  = s_now[i];
            m_changed = 1'b1;
          end
        end
        run = 0;
        for (int k = 0; k < s_hist.size() && k < DEB; k++) begin
          if (s_hist[s_hist.size() - 1 - k][i] != m_ain[i]) run++;
          else break;
        end
        if (run >= 1 && run <= DEB - 1) m_busy = 1'b1;
      end
      if (m_changed) m_evt = m_evt + 8'd1;
      while (raw_hist.size() > 16) void'(raw_hist.pop_front());
      while (s_hist.size() > 16)   void'(s_hist.pop_front());
    end
  end

  // Compare every cycle on the falling edge, well away from the active edge.
  always @(negedge clock) begin
    if (model_valid) begin
      check("ain_model", 32'(ain), 32'(m_ain));
      check("ain_changed_model", 32'(ain_changed), 32'(m_changed));
      check("busy_model", 32'(busy), 32'(m_busy));
`ifdef AIN_EVENT_COUNT_EN
      check("event_count_model", 32'(event_count), 32'(m_evt));
`endif
    end
  end

  // Advance one edge; outputs are settled 1 ns later, inputs then change.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle(input logic [W-1:0] v);
    raw_in = v;
    repeat (12) tick();
  endtask

  // Expected step response for a 00 -> 11 input held from edge 1.
  task automatic step_checks(input string tag);
    for (int e = 1; e <= 8; e++) begin
      tick();
      check({tag, "_ain"}, 32'(ain), (e >= 6) ? 32'h3 : 32'h0);
      check({tag, "_changed"}, 32'(ain_changed), (e == 6) ? 32'h1 : 32'h0);
      check({tag, "_busy"}, 32'(busy), (e >= 3 && e <= 5) ? 32'h1 : 32'h0);
    end
  endtask

  initial begin
    int t_first;
    int t_second;
    int pulses;
    logic [W-1:0] ain_first;
    logic [W-1:0] ain_second;
    int hold[W];

    // Reset hold with raw inputs high.
    reset  = 1'b1;
    raw_in = 2'b11;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_ain", 32'(ain), 32'h0);
      check("rst_changed", 32'(ain_changed), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
    end
    reset = 1'b0;
    step_checks("rst_release");

    // Clean step from a settled 00.
    settle(2'b00);
    raw_in = 2'b11;
    step_checks("step");

    // Glitch rejection: three cycles of 01 never reach ain.
    settle(2'b00);
    raw_in = 2'b01;
    repeat (3) tick();
    raw_in = 2'b00;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("glitch_ain", 32'(ain), 32'h0);
      check("glitch_changed", 32'(ain_changed), 32'h0);
    end
    check("glitch_busy_end", 32'(busy), 32'h0);

    // Independent bits: bit 1 rises two cycles after bit 0.
    raw_in = 2'b01;
    tick();
    tick();
    raw_in     = 2'b11;
    t_first    = -1;
    t_second   = -1;
    pulses     = 0;
    ain_first  = '0;
    ain_second = '0;
    for (int e = 3; e <= 20; e++) begin
      tick();
      if (ain_changed) begin
        pulses++;
        if (t_first < 0) begin
          t_first   = e;
          ain_first = ain;
        end else if (t_second < 0) begin
          t_second   = e;
          ain_second = ain;
        end
      end
    end
    check("indep_pulses", 32'(pulses), 32'd2);
    check("indep_first_edge", 32'(t_first), 32'd6);
    check("indep_first_ain", 32'(ain_first), 32'h1);
    check("indep_gap", 32'(t_second - t_first), 32'd2);
    check("indep_second_ain", 32'(ain_second), 32'h3);

    // Reset mid-count discards progress; full latency applies afterwards.
    settle(2'b00);
    raw_in = 2'b11;
    repeat (4) begin
      tick();
      check("midrst_pre_ain", 32'(ain), 32'h0);
    end
    reset = 1'b1;
    tick();
    check("midrst_during_ain", 32'(ain), 32'h0);
    reset = 1'b0;
    step_checks("midrst");

`ifdef AIN_EVENT_COUNT_EN
    // 256 accepted transitions wrap the counter back to 0, then 3 more.
    settle(2'b00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int n = 0; n < 256; n++) begin
      raw_in[0] = ~raw_in[0];
      repeat (7) tick();
    end
    check("evt_wrap", 32'(event_count), 32'd0);
    for (int n = 0; n < 3; n++) begin
      raw_in[0] = ~raw_in[0];
      repeat (7) tick();
    end
    check("evt_three", 32'(event_count), 32'd3);
`endif

    // Randomised phase: per-bit random levels with random hold lengths,
    // occasional reset pulses; the model comparison runs every cycle.
    for (int i = 0; i < W; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < W; i++) begin
        if (hold[i] == 0) begin
          raw_in[i] = 1'($urandom_range(0, 1));
          hold[i]   = $urandom_range(1, 7);
        end else begin
          hold[i]--;
        end
      end
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
